// File: rtl/tmr_err_mon_if.sv
// Report channel between tmr_err_mon (master) and the slow-control/readout consumer (slave).
// Carries the valid/ready handshake plus the captured snapshot payload.
interface tmr_err_mon_if #(
    parameter int unsigned M    = 3,
    parameter int unsigned N    = 4,
    parameter int unsigned TS_W = 32
);
    logic              rep_valid_o;
    logic              rep_ready_i;
    logic [M*N-1:0]    rep_data_o;
    logic [M-1:0]      rep_mask_o;
    logic [TS_W-1:0]   rep_ts_o;

    modport master (
        output rep_valid_o,
        input  rep_ready_i,
        output rep_data_o,
        output rep_mask_o,
        output rep_ts_o
    );

    modport slave (
        input  rep_valid_o,
        output rep_ready_i,
        input  rep_data_o,
        input  rep_mask_o,
        input  rep_ts_o
    );
endinterface

// File: rtl/tmr_err_mon.sv
// TMR error monitor: attributes voter mismatches to the faulty copies, keeps saturating
// per-copy error counters and hands a snapshot of the first unreported event to readout.
// Optional feature macro: TMR_ERR_MON_TS_EN (free-running timestamp captured with each snapshot).
module tmr_err_mon #(
    parameter int unsigned M     = 3,
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TS_W  = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic [M*N-1:0]     vtr_i,
    input  logic [N-1:0]       voted_i,
    input  logic               warn_i,
    input  logic               clr_i,
    output logic [M*CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0]   missed_o,
    tmr_err_mon_if.master      rep
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, REPORT} state_t;

    state_t             state_q, state_d;
    logic               s0_valid_q, s0_valid_d;
    logic [M*N-1:0]     s0_vtr_q, s0_vtr_d;
    logic [N-1:0]       s0_voted_q, s0_voted_d;
    logic               s0_warn_q, s0_warn_d;
    logic [CNT_W-1:0]   cnt_q [M];
    logic [CNT_W-1:0]   cnt_d [M];
    logic [CNT_W-1:0]   missed_q, missed_d;
    logic               valid_q, valid_d;
    logic [M*N-1:0]     data_q, data_d;
    logic [M-1:0]       mask_q, mask_d;
    logic [M-1:0]       mask_c;
    logic               event_c;

`ifdef TMR_ERR_MON_TS_EN
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [TS_W-1:0]    ts_cap_q, ts_cap_d;
`endif

    // Stage 0 input capture; valid follows the sample enable
    always_comb begin
        s0_valid_d = en_i;
        s0_vtr_d   = s0_vtr_q;
        s0_voted_d = s0_voted_q;
        s0_warn_d  = s0_warn_q;
        if (en_i) begin
            s0_vtr_d   = vtr_i;
            s0_voted_d = voted_i;
            s0_warn_d  = warn_i;
        end
    end

    // Stage 1 fault attribution: a copy is faulty if it differs from the voted word
    always_comb begin
        mask_c = '0;
        for (int k = 0; k < int'(M); k++) begin
            mask_c[k] = |(s0_vtr_q[k*N +: N] ^ s0_voted_q);
        end
        // warn with a clean mask still counts, exposing a broken voter warn path
        event_c = s0_valid_q & (s0_warn_q | (|mask_c));
    end

    // Counters, report FSM next state and snapshot capture; clear overrides everything
    always_comb begin
        state_d  = state_q;
        missed_d = missed_q;
        data_d   = data_q;
        mask_d   = mask_q;
        for (int k = 0; k < int'(M); k++) begin
            cnt_d[k] = cnt_q[k];
        end
`ifdef TMR_ERR_MON_TS_EN
        ts_d     = ts_q + TS_W'(1);
        ts_cap_d = ts_cap_q;
`endif
        if (clr_i) begin
            state_d  = IDLE;
            missed_d = '0;
            for (int k = 0; k < int'(M); k++) begin
                cnt_d[k] = '0;
            end
        end else begin
            if (event_c) begin
                for (int k = 0; k < int'(M); k++) begin
                    if (mask_c[k] && (cnt_q[k] != CNT_MAX)) begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (event_c) begin
                        state_d = REPORT;
                        data_d  = s0_vtr_q;
                        mask_d  = mask_c;
`ifdef TMR_ERR_MON_TS_EN
                        ts_cap_d = ts_q;
`endif
                    end
                end
                REPORT: begin
                    if (rep.rep_ready_i) begin
                        // back-to-back: a new event on the handshake edge is captured, not missed
                        if (event_c) begin
                            data_d = s0_vtr_q;
                            mask_d = mask_c;
`ifdef TMR_ERR_MON_TS_EN
                            ts_cap_d = ts_q;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (event_c && (missed_q != CNT_MAX)) begin
                        missed_d = missed_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        valid_d = (state_d == REPORT);
    end

    // State and pipeline registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            s0_valid_q <= 1'b0;
            s0_vtr_q   <= '0;
            s0_voted_q <= '0;
            s0_warn_q  <= 1'b0;
            missed_q   <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            mask_q     <= '0;
            for (int k = 0; k < int'(M); k++) begin
                cnt_q[k] <= '0;
            end
`ifdef TMR_ERR_MON_TS_EN
            ts_q       <= '0;
            ts_cap_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            s0_valid_q <= s0_valid_d;
            s0_vtr_q   <= s0_vtr_d;
            s0_voted_q <= s0_voted_d;
            s0_warn_q  <= s0_warn_d;
            missed_q   <= missed_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            for (int k = 0; k < int'(M); k++) begin
                cnt_q[k] <= cnt_d[k];
            end
`ifdef TMR_ERR_MON_TS_EN
            ts_q       <= ts_d;
            ts_cap_q   <= ts_cap_d;
`endif
        end
    end

    // Flatten the per-copy counters onto the output bus
    always_comb begin
        err_cnt_o = '0;
        for (int k = 0; k < int'(M); k++) begin
            err_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    assign missed_o        = missed_q;
    assign rep.rep_valid_o = valid_q;
    assign rep.rep_data_o  = data_q;
    assign rep.rep_mask_o  = mask_q;
`ifdef TMR_ERR_MON_TS_EN
    assign rep.rep_ts_o    = ts_cap_q;
`else
    assign rep.rep_ts_o    = TS_W'(0);
`endif

endmodule
